// File: rtl/mano_program_sequencer.sv
// Host-side loader/run controller for mano_cpu: streams (address, word) pairs onto the CPU
// load port, then releases the CPU and stops it on halt, abort or the run-cycle watchdog.
module mano_program_sequencer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned HOLD      = 1,
  parameter int unsigned RUN_LIMIT = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_halted,
  output logic              run_code,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] code,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              timeout,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StArmed = 3'd2,
    StRun   = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned       HoldW     = $clog2(HOLD + 1);
  localparam logic [HoldW-1:0]  HoldInit  = HoldW'(HOLD);
  localparam logic [ADDR_W:0]   WordsMax  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CyclesMax = '1;
  localparam logic [CNT_W:0]    LimitVal  = (CNT_W + 1)'(RUN_LIMIT);

  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic             last_q;    // final word accepted, waiting for its hold to expire
  logic             accept;
  logic [CNT_W:0]   cycles_inc;
  logic             limit_hit;

  assign state = state_q;

  always_comb begin
    accept     = ld_valid && ld_ready;
    cycles_inc = {1'b0, run_cycles} + 1'b1;
    limit_hit  = (RUN_LIMIT != 0) && (cycles_inc == LimitVal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      last_q       <= 1'b0;
      ld_ready     <= 1'b1;
      run_code     <= 1'b0;
      address      <= '0;
      code         <= '0;
      words_loaded <= '0;
      run_cycles   <= '0;
      timeout      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      if (hold_q != '0) hold_q <= hold_q - 1'b1;
      if (abort) begin
        state_q      <= StIdle;
        hold_q       <= '0;
        last_q       <= 1'b0;
        ld_ready     <= 1'b1;
        run_code     <= 1'b0;
        words_loaded <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              address      <= ld_addr;
              code         <= ld_data;
              words_loaded <= (ADDR_W + 1)'(1);
              hold_q       <= HoldInit;
              ld_ready     <= 1'b0;
              state_q      <= ld_last ? StArmed : StLoad;
            end
          end
          StLoad: begin
            if (accept) begin
              address      <= ld_addr;
              code         <= ld_data;
              words_loaded <= (words_loaded == WordsMax) ? words_loaded
                                                         : words_loaded + 1'b1;
              hold_q       <= HoldInit;
              ld_ready     <= 1'b0;
              last_q       <= ld_last;
            end else if (hold_q <= HoldW'(1)) begin
              // Hold expires at this edge: reopen the port or arm if that was the last word.
              if (last_q) begin
                state_q  <= StArmed;
                last_q   <= 1'b0;
                ld_ready <= 1'b0;
              end else begin
                ld_ready <= 1'b1;
              end
            end
          end
          StArmed: begin
            ld_ready <= 1'b0;
            if (start) begin
              state_q    <= StRun;
              run_code   <= 1'b1;
              run_cycles <= '0;
              timeout    <= 1'b0;
              halted     <= 1'b0;
            end
          end
          StRun: begin
            run_cycles <= (run_cycles == CyclesMax) ? run_cycles : cycles_inc[CNT_W-1:0];
            if (cpu_halted) begin
              state_q  <= StDone;
              run_code <= 1'b0;
              halted   <= 1'b1;
              ld_ready <= 1'b1;
            end else if (limit_hit) begin
              state_q  <= StDone;
              run_code <= 1'b0;
              timeout  <= 1'b1;
              ld_ready <= 1'b1;
            end
          end
          StDone: begin
            if (accept) begin
              address      <= ld_addr;
              code         <= ld_data;
              words_loaded <= (ADDR_W + 1)'(1);
              hold_q       <= HoldInit;
              ld_ready     <= 1'b0;
              last_q       <= ld_last;
              state_q      <= StLoad;
            end else if (start) begin
              state_q    <= StRun;
              run_code   <= 1'b1;
              run_cycles <= '0;
              timeout    <= 1'b0;
              halted     <= 1'b0;
              ld_ready   <= 1'b0;
            end
          end
          default: begin
            state_q      <= StIdle;
            hold_q       <= '0;
            last_q       <= 1'b0;
            ld_ready     <= 1'b1;
            run_code     <= 1'b0;
            words_loaded <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mano_program_sequencer.sv
// Bench for mano_program_sequencer: directed table/sequence checks plus random stimulus
// compared every cycle against an edge-count based behavioural model.
module tb_mano_program_sequencer;
  localparam int AW = 12, WW = 16, CW = 16, LIM = 10;

  logic clk = 1'b0;
  logic rst, ld_valid, ld_last, start, abort, cpu_halted;
  logic [AW-1:0] ld_addr;
  logic [WW-1:0] ld_data;

  logic ld_ready, run_code, timeout, halted;
  logic [AW-1:0] address;
  logic [WW-1:0] code;
  logic [2:0] state;
  logic [AW:0] words_loaded;
  logic [CW-1:0] run_cycles;

  logic ld_ready3, run_code3, timeout3, halted3;
  logic [AW-1:0] address3;
  logic [WW-1:0] code3;
  logic [2:0] state3;
  logic [AW:0] words_loaded3;
  logic [CW-1:0] run_cycles3;

  mano_program_sequencer #(.ADDR_W(AW), .WORD_W(WW), .HOLD(1), .RUN_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .abort(abort),
    .cpu_halted(cpu_halted), .run_code(run_code), .address(address), .code(code),
    .state(state), .words_loaded(words_loaded), .run_cycles(run_cycles),
    .timeout(timeout), .halted(halted)
  );

  mano_program_sequencer #(.ADDR_W(AW), .WORD_W(WW), .HOLD(3), .RUN_LIMIT(0), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready3), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .abort(abort),
    .cpu_halted(cpu_halted), .run_code(run_code3), .address(address3), .code(code3),
    .state(state3), .words_loaded(words_loaded3), .run_cycles(run_cycles3),
    .timeout(timeout3), .halted(halted3)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: modes 0..4 as named in the interface; ld_ready derived from edge count.
  int m_mode, m_n, m_rdy_edge, m_words, m_runc;
  bit m_pend, m_rc, m_to, m_ha;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_code;

  function automatic bit m_ready();
    return (m_mode == 0 || m_mode == 1 || m_mode == 4) && !m_pend && (m_n >= m_rdy_edge);
  endfunction

  function automatic logic [63:0] model_vec();
    return {m_ready(), m_rc, m_addr, m_code, 3'(m_mode), 13'(m_words), 16'(m_runc), m_to, m_ha};
  endfunction

  wire [63:0] dut_vec = {ld_ready, run_code, address, code, state, words_loaded, run_cycles,
                         timeout, halted};

  task automatic begin_run();
    m_mode = 3; m_rc = 1; m_runc = 0; m_to = 0; m_ha = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = ld_valid && m_ready();
    m_n++;
    if (rst) begin
      m_mode = 0; m_rc = 0; m_addr = '0; m_code = '0; m_words = 0; m_runc = 0;
      m_to = 0; m_ha = 0; m_pend = 0; m_rdy_edge = m_n;
    end else if (abort) begin
      m_mode = 0; m_rc = 0; m_words = 0; m_pend = 0; m_rdy_edge = m_n;
    end else begin
      case (m_mode)
        0: if (acc) begin
          m_addr = ld_addr; m_code = ld_data; m_words = 1; m_rdy_edge = m_n + 1;
          m_mode = ld_last ? 2 : 1;
        end
        1: if (acc) begin
          m_addr = ld_addr; m_code = ld_data; m_rdy_edge = m_n + 1; m_pend = ld_last;
          m_words = (m_words >= 4096) ? 4096 : m_words + 1;
        end
        2: if (start) begin_run();
        3: begin
          m_runc = (m_runc >= 65535) ? 65535 : m_runc + 1;
          if (cpu_halted) begin m_mode = 4; m_rc = 0; m_ha = 1; end
          else if (m_runc == LIM) begin m_mode = 4; m_rc = 0; m_to = 1; end
        end
        default: if (acc) begin
          m_addr = ld_addr; m_code = ld_data; m_words = 1; m_rdy_edge = m_n + 1;
          m_pend = ld_last; m_mode = 1;
        end else if (start) begin
          begin_run();
        end
      endcase
      if (m_mode == 1 && m_pend && m_n >= m_rdy_edge) begin
        m_mode = 2; m_pend = 0;
      end
    end
  endtask

  task automatic go();
    model_step();
    @(posedge clk);
    #1;
    chk("model", dut_vec, model_vec());
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    logic          l;
    int            exp_words;
    logic [2:0]    exp_state;
    logic          exp_ready;
  } ld_vec_t;

  ld_vec_t prog[7];
  int cnt;

  initial begin
    prog[0] = '{12'h000, 16'h2004, 1'b0, 1, 3'd1, 1'b1};
    prog[1] = '{12'h001, 16'h1005, 1'b0, 2, 3'd1, 1'b1};
    prog[2] = '{12'h002, 16'h3006, 1'b0, 3, 3'd1, 1'b1};
    prog[3] = '{12'h003, 16'h7001, 1'b0, 4, 3'd1, 1'b1};
    prog[4] = '{12'h004, 16'h0053, 1'b0, 5, 3'd1, 1'b1};
    prog[5] = '{12'h005, 16'hFFE9, 1'b0, 6, 3'd1, 1'b1};
    prog[6] = '{12'h006, 16'h0000, 1'b1, 7, 3'd2, 1'b0};

    m_mode = 0; m_n = 0; m_rdy_edge = 0; m_words = 0; m_runc = 0;
    m_pend = 0; m_rc = 0; m_to = 0; m_ha = 0; m_addr = '0; m_code = '0;
    rst = 1; ld_valid = 0; ld_last = 0; start = 0; abort = 0; cpu_halted = 0;
    ld_addr = '0; ld_data = '0;
    go(); go();
    rst = 0;
    chk("reset_vec", dut_vec, 64'h8000_0000_0000_0000);

    // Program load, one word per two cycles
    foreach (prog[i]) begin
      ld_valid = 1; ld_addr = prog[i].a; ld_data = prog[i].d; ld_last = prog[i].l;
      go();
      chk("load_addr", 64'(address), 64'(prog[i].a));
      chk("load_code", 64'(code), 64'(prog[i].d));
      chk("load_busy", 64'(ld_ready), 64'd0);
      chk("load_runcode", 64'(run_code), 64'd0);
      chk("load_words", 64'(words_loaded), 64'(prog[i].exp_words));
      ld_valid = 0; ld_last = 0;
      go();
      chk("load_state", 64'(state), 64'(prog[i].exp_state));
      chk("load_ready", 64'(ld_ready), 64'(prog[i].exp_ready));
    end

    // Watchdog run
    start = 1; go(); start = 0;
    cnt = run_code ? 1 : 0;
    for (int k = 0; k < 40 && run_code; k++) begin
      go();
      if (run_code) cnt++;
    end
    chk("limit_bound", 64'(run_code), 64'd0);
    chk("limit_len", 64'(cnt), 64'd10);
    chk("limit_cycles", 64'(run_cycles), 64'd10);
    chk("limit_timeout", 64'(timeout), 64'd1);
    chk("limit_state", 64'(state), 64'd4);

    // Re-run from DONE, halt in 4th run cycle
    start = 1; go(); start = 0;
    go(); go(); go();
    cpu_halted = 1; go(); cpu_halted = 0;
    chk("halt_runcode", 64'(run_code), 64'd0);
    chk("halt_cycles", 64'(run_cycles), 64'd4);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_timeout", 64'(timeout), 64'd0);

    // Load beats start in DONE
    start = 1; ld_valid = 1; ld_addr = 12'h010; ld_data = 16'h1234;
    go(); start = 0; ld_valid = 0;
    chk("reload_state", 64'(state), 64'd1);
    chk("reload_addr", 64'(address), 64'h010);
    chk("reload_code", 64'(code), 64'h1234);
    chk("reload_runcode", 64'(run_code), 64'd0);

    // Abort during LOAD after three words
    go();
    for (int w = 0; w < 2; w++) begin
      ld_valid = 1; ld_addr = 12'h011 + 12'(w); ld_data = 16'h0AA0 + 16'(w);
      go(); ld_valid = 0; go();
    end
    chk("abort_load_pre", 64'(words_loaded), 64'd3);
    abort = 1; go(); abort = 0;
    chk("abort_load_state", 64'(state), 64'd0);
    chk("abort_load_words", 64'(words_loaded), 64'd0);
    chk("abort_load_ready", 64'(ld_ready), 64'd1);

    // Abort mid-RUN
    ld_valid = 1; ld_last = 1; ld_addr = 12'h020; ld_data = 16'h7001;
    go(); ld_valid = 0; ld_last = 0;
    chk("single_armed", 64'(state), 64'd2);
    start = 1; go(); start = 0; go(); go();
    chk("abort_run_pre", 64'(run_code), 64'd1);
    abort = 1; go(); abort = 0;
    chk("abort_run_state", 64'(state), 64'd0);
    chk("abort_run_runcode", 64'(run_code), 64'd0);
    chk("abort_run_words", 64'(words_loaded), 64'd0);

    // HOLD=3 instance: continuous ld_valid -> one acceptance every 4 cycles
    ld_valid = 1;
    for (int i = 0; i < 12; i++) begin
      ld_addr = 12'h100 + 12'(i); ld_data = 16'(i);
      go();
      chk("hold3_words", 64'(words_loaded3), 64'(i / 4 + 1));
      chk("hold3_addr", 64'(address3), 64'(12'h100 + 12'((i / 4) * 4)));
      chk("hold3_ready", 64'(ld_ready3), 64'((i % 4) == 3));
    end
    ld_valid = 0;

    // Synchronous reset mid-RUN
    abort = 1; go(); abort = 0;
    ld_valid = 1; ld_last = 1; go(); ld_valid = 0; ld_last = 0;
    start = 1; go(); start = 0; go();
    chk("rst_run_pre", 64'(run_code), 64'd1);
    rst = 1; go(); rst = 0;
    chk("rst_run_vec", dut_vec, 64'h8000_0000_0000_0000);
    chk("rst_run_vec3", {ld_ready3, run_code3, address3, code3, state3, words_loaded3,
                         run_cycles3, timeout3, halted3}, 64'h8000_0000_0000_0000);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst        = ($urandom_range(0, 199) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      start      = ($urandom_range(0, 3) == 0);
      ld_valid   = ($urandom_range(0, 1) == 0);
      ld_last    = ($urandom_range(0, 5) == 0);
      cpu_halted = ($urandom_range(0, 15) == 0);
      ld_addr    = AW'($urandom);
      ld_data    = WW'($urandom);
      go();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
